// File: rtl/mem_block_arbiter.sv
// Two-requester block arbiter: grants a 4-word block read/write to the page-table
// walker or the data cache and sequences it as single-word memory transactions.
module mem_block_arbiter #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int BLOCK_WIDTH     = DATA_WIDTH * WORDS_PER_BLOCK
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic                   req0_write,
  input  logic [ADDR_WIDTH-1:0]  req0_addr,
  input  logic [BLOCK_WIDTH-1:0] req0_wdata,
  output logic                   req0_ack,
  output logic [BLOCK_WIDTH-1:0] req0_rdata,
  input  logic                   req1_valid,
  input  logic                   req1_write,
  input  logic [ADDR_WIDTH-1:0]  req1_addr,
  input  logic [BLOCK_WIDTH-1:0] req1_wdata,
  output logic                   req1_ack,
  output logic [BLOCK_WIDTH-1:0] req1_rdata,
  output logic                   mem_read_or_write,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic [DATA_WIDTH-1:0]  mem_write_data,
  input  logic                   mem_done,
  input  logic [DATA_WIDTH-1:0]  mem_read_data,
  output logic                   busy
);
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W = IDX_W + 2;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS_PER_BLOCK - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]             state;
  logic [IDX_W-1:0]       idx;
  logic                   prio;
  logic                   owner;
  logic                   wr;
  logic [ADDR_WIDTH-1:0]  blk_addr;
  logic [BLOCK_WIDTH-1:0] wbuf;
  logic [BLOCK_WIDTH-1:0] rbuf;
  logic                   done_q;

  logic                   gnt_any;
  logic                   gnt_sel;
  logic                   sel_write;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [BLOCK_WIDTH-1:0] sel_wdata;
  logic [IDX_W-1:0]       idx_inc;
  logic                   done_rise;
  logic [BLOCK_WIDTH-1:0] rbuf_next;

  always_comb begin
    gnt_any   = req0_valid | req1_valid;
    gnt_sel   = (req0_valid && req1_valid) ? prio : req1_valid;
    sel_write = gnt_sel ? req1_write : req0_write;
    sel_addr  = (gnt_sel ? req1_addr : req0_addr) & ~OFF_MASK;
    sel_wdata = gnt_sel ? req1_wdata : req0_wdata;
    idx_inc   = idx + 1'b1;
    // A held done level must count once, so only the rising edge advances a word.
    done_rise = mem_done & ~done_q;
    rbuf_next = rbuf;
    rbuf_next[idx*DATA_WIDTH +: DATA_WIDTH] = mem_read_data;
  end

  assign busy     = (state != S_IDLE);
  assign req0_ack = (state == S_RESP) && !owner;
  assign req1_ack = (state == S_RESP) && owner;

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_IDLE;
      idx               <= '0;
      prio              <= 1'b0;
      owner             <= 1'b0;
      wr                <= 1'b0;
      blk_addr          <= '0;
      wbuf              <= '0;
      rbuf              <= '0;
      done_q            <= 1'b0;
      req0_rdata        <= '0;
      req1_rdata        <= '0;
      mem_read_or_write <= 1'b0;
      mem_address       <= '0;
      mem_write_data    <= '0;
    end else begin
      done_q <= mem_done;
      case (state)
        S_IDLE: if (gnt_any) begin
          owner             <= gnt_sel;
          wr                <= sel_write;
          blk_addr          <= sel_addr;
          wbuf              <= sel_wdata;
          idx               <= '0;
          // Word outputs are loaded on the edge into ISSUE so they are already
          // presented to memory for the whole ISSUE cycle.
          mem_address       <= sel_addr;
          mem_read_or_write <= sel_write;
          if (sel_write) mem_write_data <= sel_wdata[DATA_WIDTH-1:0];
          state             <= S_ISSUE;
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: if (done_rise) begin
          if (!wr) rbuf <= rbuf_next;
          if (idx == LAST) begin
            if (!wr && owner)  req1_rdata <= rbuf_next;
            if (!wr && !owner) req0_rdata <= rbuf_next;
            state <= S_RESP;
          end else begin
            idx         <= idx_inc;
            mem_address <= blk_addr | ADDR_WIDTH'({idx_inc, 2'b00});
            if (wr) mem_write_data <= wbuf[idx_inc*DATA_WIDTH +: DATA_WIDTH];
            state       <= S_ISSUE;
          end
        end
        S_RESP: begin
          prio  <= ~owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_block_arbiter.sv
// Bench for mem_block_arbiter: randomized memory responder plus a word-array
// reference model of memory contents, arbitration order and returned blocks.
module tb_mem_block_arbiter;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req0_write = 1'b0;
  logic [9:0]   req0_addr = '0;
  logic [127:0] req0_wdata = '0;
  logic         req0_ack;
  logic [127:0] req0_rdata;
  logic         req1_valid = 1'b0, req1_write = 1'b0;
  logic [9:0]   req1_addr = '0;
  logic [127:0] req1_wdata = '0;
  logic         req1_ack;
  logic [127:0] req1_rdata;
  logic         mem_read_or_write;
  logic [9:0]   mem_address;
  logic [31:0]  mem_write_data;
  logic         mem_done = 1'b0;
  logic [31:0]  mem_read_data = '0;
  logic         busy;

  always #5 clock = ~clock;

  mem_block_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_rdata(req1_rdata),
    .mem_read_or_write(mem_read_or_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_done(mem_done),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  typedef struct { logic [9:0] addr; logic wr; logic [31:0] data; } txn_t;

  logic [31:0]  env_mem [256];
  logic [31:0]  ref_mem [256];
  logic [127:0] last_rd [2];
  int           prio_m = 0;
  txn_t         log_q[$];
  int           dly_lo = 1, dly_hi = 2, hold_lo = 1, hold_hi = 1;
  int           passed = 0, total = 0;

  // Memory device: one transaction per new address while busy, done after a delay.
  initial begin : responder
    logic [9:0] a; logic w; logic [31:0] d; bit served; logic [9:0] served_a; bit alive;
    served = 0; served_a = '0;
    forever begin
      @(posedge clock); #1;
      if (!busy) served = 0;
      else if (!(served && mem_address == served_a)) begin
        a = mem_address; w = mem_read_or_write; d = mem_write_data;
        log_q.push_back('{addr: a, wr: w, data: d});
        alive = 1;
        repeat ($urandom_range(dly_hi, dly_lo)) begin
          @(posedge clock); #1;
          if (!busy) alive = 0;
        end
        if (alive) begin
          mem_done = 1'b1;
          mem_read_data = env_mem[a[9:2]];
          if (w) env_mem[a[9:2]] = d;
          repeat ($urandom_range(hold_hi, hold_lo)) begin @(posedge clock); #1; end
          mem_done = 1'b0;
          mem_read_data = $urandom;
          served = 1; served_a = a;
        end else served = 0;
      end
    end
  end

  function automatic logic [127:0] exp_block(input logic [9:0] a);
    logic [127:0] b;
    int base = int'(a & 10'h3F0) >> 2;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = ref_mem[base+i];
    return b;
  endfunction

  task automatic model_write(input logic [9:0] a, input logic [127:0] wd);
    int base = int'(a & 10'h3F0) >> 2;
    for (int i = 0; i < 4; i++) ref_mem[base+i] = wd[i*32 +: 32];
  endtask

  // Drives one request to completion; reports timeout, the rdata seen at ack and ack count.
  task automatic run_xfer(input int r, input logic w, input logic [9:0] a, input logic [127:0] wd,
                          output bit tmo, output logic [127:0] rd, output int acks);
    log_q.delete();
    tmo = 1; rd = '0; acks = 0;
    if (r == 0) begin req0_write = w; req0_addr = a; req0_wdata = wd; req0_valid = 1; end
    else        begin req1_write = w; req1_addr = a; req1_wdata = wd; req1_valid = 1; end
    for (int c = 0; c < 500; c++) begin
      @(posedge clock); #1;
      if (req0_ack || req1_ack) begin
        acks = 1;
        if ((r == 0 && req0_ack) || (r == 1 && req1_ack)) tmo = 0;
        rd = (r == 0) ? req0_rdata : req1_rdata;
        break;
      end
    end
    req0_valid = 0; req1_valid = 0;
    @(posedge clock); #1;
    if (req0_ack || req1_ack) acks++;
    if (!tmo) prio_m = 1 - r;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if ({req0_ack, req1_ack} !== 2'b00) $display("FAIL reset_ack got %b exp 00", {req0_ack, req1_ack}); else passed++;
    total++; if ({req0_rdata, req1_rdata} !== 256'd0) $display("FAIL reset_rdata got %h %h exp 0", req0_rdata, req1_rdata); else passed++;
    total++; if ({mem_read_or_write, mem_address, mem_write_data} !== 43'd0)
      $display("FAIL reset_mem got rw=%b a=%h d=%h exp 0", mem_read_or_write, mem_address, mem_write_data); else passed++;
    reset = 0;
    prio_m = 0; last_rd[0] = '0; last_rd[1] = '0;
    @(posedge clock); #1;
  endtask

  task automatic test_read();
    bit tmo; logic [127:0] rd; int acks;
    logic [127:0] exp = exp_block(10'h100);
    run_xfer(0, 1'b0, 10'h100, '0, tmo, rd, acks);
    total++; if (tmo || acks != 1) $display("FAIL read_ack got tmo=%0d acks=%0d exp 0/1", tmo, acks); else passed++;
    total++; if (rd !== 128'h55555555_66666666_77777777_88888888 || rd !== exp)
      $display("FAIL read_rdata got %h exp %h", rd, exp); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_q.size() != 4 || log_q[i].addr !== 10'(10'h100 + 4*i) || log_q[i].wr !== 1'b0)
        $display("FAIL read_word%0d got n=%0d a=%h rw=%b exp a=%h rw=0", i, log_q.size(), log_q[i].addr, log_q[i].wr, 10'(10'h100 + 4*i));
      else passed++;
    end
    last_rd[0] = exp;
  endtask

  task automatic test_write();
    bit tmo; logic [127:0] rd; int acks;
    logic [127:0] wd = 128'h0000000D_0000000C_0000000B_0000000A;
    run_xfer(1, 1'b1, 10'h040, wd, tmo, rd, acks);
    model_write(10'h040, wd);
    total++; if (tmo || acks != 1) $display("FAIL write_ack got tmo=%0d acks=%0d exp 0/1", tmo, acks); else passed++;
    total++; if (rd !== last_rd[1]) $display("FAIL write_rdata_kept got %h exp %h", rd, last_rd[1]); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_q.size() != 4 || log_q[i].addr !== 10'(10'h040 + 4*i) || log_q[i].wr !== 1'b1 || log_q[i].data !== 32'(10 + i))
        $display("FAIL write_word%0d got n=%0d a=%h rw=%b d=%h exp a=%h rw=1 d=%h", i, log_q.size(), log_q[i].addr, log_q[i].wr, log_q[i].data, 10'(10'h040 + 4*i), 32'(10 + i));
      else passed++;
    end
    run_xfer(1, 1'b0, 10'h040, '0, tmo, rd, acks);
    total++; if (tmo || acks != 1 || rd !== wd) $display("FAIL write_readback got %h tmo=%0d exp %h", rd, tmo, wd); else passed++;
    last_rd[1] = wd;
  endtask

  task automatic test_priority();
    int order[4]; logic [127:0] rds[4]; int n = 0; int both = 0;
    logic [127:0] e[2];
    int first = prio_m;
    e[0] = exp_block(10'h200); e[1] = exp_block(10'h300);
    req0_write = 0; req0_addr = 10'h200; req1_write = 0; req1_addr = 10'h300;
    req0_valid = 1; req1_valid = 1;
    for (int c = 0; c < 3000 && n < 4; c++) begin
      @(posedge clock); #1;
      if (req0_ack && req1_ack) both++;
      if (req0_ack)      begin order[n] = 0; rds[n] = req0_rdata; n++; end
      else if (req1_ack) begin order[n] = 1; rds[n] = req1_rdata; n++; end
    end
    req0_valid = 0; req1_valid = 0;
    @(posedge clock); #1;
    total++; if (n != 4 || both != 0) $display("FAIL prio_count got n=%0d both=%0d exp 4/0", n, both); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (order[k] != (first + k) % 2 || rds[k] !== e[(first + k) % 2])
        $display("FAIL prio_grant%0d got req%0d %h exp req%0d %h", k, order[k], rds[k], (first + k) % 2, e[(first + k) % 2]);
      else passed++;
    end
    last_rd[0] = e[0]; last_rd[1] = e[1];
  endtask

  task automatic test_done_hold();
    bit tmo; logic [127:0] rd; int acks;
    logic [127:0] exp = exp_block(10'h180);
    hold_lo = 3; hold_hi = 3;
    run_xfer(0, 1'b0, 10'h180, '0, tmo, rd, acks);
    total++; if (tmo || acks != 1 || rd !== exp) $display("FAIL hold_read got %h tmo=%0d acks=%0d exp %h", rd, tmo, acks, exp); else passed++;
    total++;
    if (log_q.size() != 4 || log_q[0].addr !== 10'h180 || log_q[1].addr !== 10'h184 || log_q[2].addr !== 10'h188 || log_q[3].addr !== 10'h18C)
      $display("FAIL hold_words got n=%0d exp 4 words 180..18C", log_q.size());
    else passed++;
    hold_lo = 1; hold_hi = 1;
    last_rd[0] = exp;
  endtask

  task automatic test_reset_mid();
    bit tmo; logic [127:0] rd; int acks; bit found = 0; int stray = 0;
    logic [127:0] exp = exp_block(10'h0C0);
    dly_lo = 3; dly_hi = 3;
    req1_write = 0; req1_addr = 10'h080; req1_valid = 1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clock); #1;
      if (busy && mem_address == 10'h088) begin found = 1; break; end
    end
    total++; if (!found) $display("FAIL rstmid_reach got no word2 exp word2 at 088"); else passed++;
    @(posedge clock); #1;
    reset = 1; req1_valid = 0;
    @(posedge clock); #1;
    total++; if (busy !== 1'b0 || mem_address !== 10'h000 || req0_ack || req1_ack)
      $display("FAIL rstmid_state got busy=%b a=%h ack=%b%b exp 0 000 00", busy, mem_address, req0_ack, req1_ack); else passed++;
    reset = 0;
    prio_m = 0; last_rd[0] = '0; last_rd[1] = '0;
    repeat (8) begin @(posedge clock); #1; if (req0_ack || req1_ack || busy) stray++; end
    total++; if (stray != 0 || req1_rdata !== 128'd0) $display("FAIL rstmid_quiet got stray=%0d rdata=%h exp 0", stray, req1_rdata); else passed++;
    dly_lo = 1; dly_hi = 2;
    run_xfer(1, 1'b0, 10'h0C0, '0, tmo, rd, acks);
    total++; if (tmo || acks != 1 || rd !== exp) $display("FAIL rstmid_after got %h tmo=%0d exp %h", rd, tmo, exp); else passed++;
    last_rd[1] = exp;
  endtask

  task automatic test_misaligned();
    bit tmo; logic [127:0] rd; int acks;
    logic [127:0] exp = exp_block(10'h100);
    run_xfer(0, 1'b0, 10'h10F, '0, tmo, rd, acks);
    total++; if (tmo || acks != 1 || rd !== exp) $display("FAIL misalign_rdata got %h exp %h", rd, exp); else passed++;
    total++;
    if (log_q.size() != 4 || log_q[0].addr !== 10'h100 || log_q[1].addr !== 10'h104 || log_q[2].addr !== 10'h108 || log_q[3].addr !== 10'h10C)
      $display("FAIL misalign_words got n=%0d first=%h exp 100..10C", log_q.size(), log_q[0].addr);
    else passed++;
    last_rd[0] = exp;
  endtask

  task automatic test_random();
    bit tmo; logic [127:0] rd, wd, exp; int acks, r; logic w; logic [9:0] a, base;
    dly_lo = 1; dly_hi = 4; hold_lo = 1; hold_hi = 3;
    for (int t = 0; t < 16; t++) begin
      r = $urandom_range(1, 0); w = 1'($urandom_range(1, 0)); a = 10'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      base = a & 10'h3F0;
      exp = w ? last_rd[r] : exp_block(a);
      run_xfer(r, w, a, wd, tmo, rd, acks);
      if (w) model_write(a, wd); else last_rd[r] = exp;
      total++; if (tmo || acks != 1 || rd !== exp)
        $display("FAIL rand%0d_block req%0d w=%b a=%h got %h tmo=%0d exp %h", t, r, w, a, rd, tmo, exp); else passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (log_q.size() != 4 || log_q[i].addr !== 10'(base + 4*i) || log_q[i].wr !== w || (w && log_q[i].data !== wd[i*32 +: 32]))
          $display("FAIL rand%0d_word%0d got a=%h rw=%b d=%h exp a=%h rw=%b", t, i, log_q[i].addr, log_q[i].wr, log_q[i].data, 10'(base + 4*i), w);
        else passed++;
      end
    end
    dly_lo = 1; dly_hi = 2; hold_lo = 1; hold_hi = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom; ref_mem[i] = env_mem[i];
    end
    env_mem[64] = 32'h88888888; env_mem[65] = 32'h77777777;
    env_mem[66] = 32'h66666666; env_mem[67] = 32'h55555555;
    for (int i = 64; i < 68; i++) ref_mem[i] = env_mem[i];
    test_reset();
    test_read();
    test_write();
    test_priority();
    test_done_hold();
    test_reset_mid();
    test_misaligned();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
